// File: rtl/lockstep_alu_checker.sv
// Dual-channel ALU with a 2-stage pipeline, lockstep compare, mismatch counters and a latched FAULT.
// Optional FAULT_INJECT_EN adds inj_i, which flips bit 0 of a transaction's channel-2 result.
module lockstep_alu_checker #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8,
    parameter int LIMIT     = 3
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a0_i,
    input  logic [WIDTH-1:0]     b0_i,
    input  logic [1:0]           sel0_i,
    input  logic [WIDTH-1:0]     a1_i,
    input  logic [WIDTH-1:0]     b1_i,
    input  logic [1:0]           sel1_i,
`ifdef FAULT_INJECT_EN
    input  logic                 inj_i,
`endif
    input  logic                 clr_i,
    output logic                 out_valid_o,
    output logic [WIDTH-1:0]     out1_o,
    output logic [WIDTH-1:0]     out2_o,
    output logic                 carry1_o,
    output logic                 carry2_o,
    output logic [WIDTH-1:0]     diff_o,
    output logic                 cdiff_o,
    output logic                 mismatch_o,
    output logic                 err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [1:0]           state_o,
    output logic                 fault_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FAULT = 2'b10} state_t;

    state_t           state, state_nx;
    logic             xfer;
    logic             s1_vld;
    logic [WIDTH-1:0] s1_a0, s1_b0, s1_a1, s1_b1;
    logic [1:0]       s1_sel0, s1_sel1;
    logic             s1_inj;
    logic [WIDTH:0]   res0, res1;
    logic [7:0]       consec, consec_inc;
    logic             hit_limit;

    // Top bit of the (WIDTH+1)-bit result is carry for ADD and borrow for SUB.
    function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic [1:0] sel);
        case (sel)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign in_ready_o = (state != FAULT);
    assign xfer       = in_valid_i & in_ready_o;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            s1_vld  <= 1'b0;
            s1_a0   <= '0;
            s1_b0   <= '0;
            s1_a1   <= '0;
            s1_b1   <= '0;
            s1_sel0 <= '0;
            s1_sel1 <= '0;
            s1_inj  <= 1'b0;
        end else begin
            s1_vld <= xfer;
            if (xfer) begin
                s1_a0   <= a0_i;
                s1_b0   <= b0_i;
                s1_sel0 <= sel0_i;
                s1_a1   <= a1_i;
                s1_b1   <= b1_i;
                s1_sel1 <= sel1_i;
`ifdef FAULT_INJECT_EN
                s1_inj  <= inj_i;
`else
                s1_inj  <= 1'b0;
`endif
            end
        end
    end

    assign res0 = alu(s1_a0, s1_b0, s1_sel0);
    assign res1 = alu(s1_a1, s1_b1, s1_sel1) ^ {{WIDTH{1'b0}}, s1_inj};

    // Result registers only load on a valid stage-1 entry, so they hold between transactions.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            out_valid_o <= 1'b0;
            out1_o      <= '0;
            out2_o      <= '0;
            carry1_o    <= 1'b0;
            carry2_o    <= 1'b0;
            diff_o      <= '0;
            cdiff_o     <= 1'b0;
        end else begin
            out_valid_o <= s1_vld;
            if (s1_vld) begin
                out1_o   <= res0[WIDTH-1:0];
                out2_o   <= res1[WIDTH-1:0];
                carry1_o <= res0[WIDTH];
                carry2_o <= res1[WIDTH];
                diff_o   <= res0[WIDTH-1:0] ^ res1[WIDTH-1:0];
                cdiff_o  <= res0[WIDTH] ^ res1[WIDTH];
            end
        end
    end

    assign mismatch_o = out_valid_o & ((|diff_o) | cdiff_o);
    assign consec_inc = (consec == 8'hFF) ? consec : consec + 8'd1;
    assign hit_limit  = mismatch_o && (consec_inc >= 8'(LIMIT));

    // clr_i wins over a mismatch arriving in the same cycle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || clr_i) begin
            err_cnt_o    <= '0;
            err_sticky_o <= 1'b0;
            consec       <= '0;
        end else if (mismatch_o) begin
            if (!(&err_cnt_o))
                err_cnt_o <= err_cnt_o + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            err_sticky_o <= 1'b1;
            consec       <= consec_inc;
        end else if (out_valid_o) begin
            consec <= '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!clr_i && hit_limit) state_nx = FAULT;
                     else if (xfer)           state_nx = RUN;
            RUN:     if (!clr_i && hit_limit) state_nx = FAULT;
                     else if (!xfer && !s1_vld && !out_valid_o) state_nx = IDLE;
            FAULT:   if (clr_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign state_o = state;
    assign fault_o = (state == FAULT);
endmodule
